// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and index-width helper for the matrix loader path
package matrix_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } load_state_t;

  // Index width for a DIM-long walk; never narrower than one bit.
  function automatic int idx_w(input int dim);
    return (dim > 2) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/mat_index_counter.sv
// rtl/mat_index_counter.sv - row-major (row, col) walk over a DIM x DIM grid
module mat_index_counter
  import matrix_pkg::*;
#(
  parameter  int DIM = 4,
  localparam int IW  = idx_w(DIM)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [IW-1:0] row_o,
  output logic [IW-1:0] col_o,
  output logic          at_last_o
);

  localparam logic [IW-1:0] LAST = IW'(DIM - 1);

  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Wrap explicitly at DIM-1 so non-power-of-two DIM never overruns.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign row_o     = row_q;
  assign col_o     = col_q;
  assign at_last_o = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - streams elements into a DIM x DIM operand matrix and holds it until released
// Optional build macro MATRIX_LOADER_TRANSPOSE_EN stores each element at mat[col][row].
module matrix_loader
  import matrix_pkg::*;
#(
  parameter  int DIM   = 4,
  parameter  int WIDTH = 8,
  localparam int IW    = idx_w(DIM)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                s_valid_i,
  output logic                                s_ready_o,
  input  logic [WIDTH-1:0]                    s_data_i,
  input  logic                                s_last_i,
  output logic [DIM-1:0][DIM-1:0][WIDTH-1:0]  mat_o,
  output logic                                mat_valid_o,
  input  logic                                mat_release_i,
  output logic                                err_last_o
);

  load_state_t state_q, state_d;

  logic [DIM-1:0][DIM-1:0][WIDTH-1:0] mat_q, mat_d;
  logic                               err_q, err_d;

  logic          accept;
  logic          release_hit;
  logic          at_last;
  logic [IW-1:0] row, col;
  logic [IW-1:0] wr_row, wr_col;

  assign accept      = s_valid_i && (state_q == FILL);
  assign release_hit = mat_release_i && (state_q == FULL);

  mat_index_counter #(.DIM(DIM)) u_idx (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (accept),
    .clr_i     (release_hit),
    .row_o     (row),
    .col_o     (col),
    .at_last_o (at_last)
  );

`ifdef MATRIX_LOADER_TRANSPOSE_EN
  assign wr_row = col;
  assign wr_col = row;
`else
  assign wr_row = row;
  assign wr_col = col;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= FILL;
      mat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && at_last) state_d = FULL;
      FULL:    if (mat_release_i)     state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Contents survive a release; the next fill simply overwrites them.
  always_comb begin
    mat_d = mat_q;
    err_d = err_q;
    if (accept) begin
      mat_d[wr_row][wr_col] = s_data_i;
      if (s_last_i != at_last) err_d = 1'b1;
    end
  end

  always_comb begin
    s_ready_o   = (state_q == FILL);
    mat_valid_o = (state_q == FULL);
  end

  assign mat_o      = mat_q;
  assign err_last_o = err_q;

endmodule
